// File: rtl/register_file_sb.sv
// Register file with two combinational read ports, one clocked write port and a per-register busy scoreboard.
// Latency: reads, bypass and stall are combinational; writes and scoreboard updates take effect at the next rising clk.
// Backpressure: stall tells decode to hold; an issue made while stall is high is dropped and must be retried.
module register_file_sb #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 4,
    parameter int BYPASS  = 1,
    parameter int R0_ZERO = 0
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic [ADDR_W-1:0]    ra,
    input  logic [ADDR_W-1:0]    rb,
    output logic [DATA_W-1:0]    A,
    output logic [DATA_W-1:0]    B,
    input  logic                 use_a,
    input  logic                 use_b,
    input  logic [ADDR_W-1:0]    rc,
    input  logic [DATA_W-1:0]    C,
    input  logic                 le,
    input  logic                 issue_v,
    input  logic [ADDR_W-1:0]    issue_rd,
    output logic                 stall,
    output logic [2**ADDR_W-1:0] busy
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;

    logic wr_en;
    logic wb_hit_a;
    logic wb_hit_b;
    logic haz_a;
    logic haz_b;
    logic issue_eff;

    // Write strobe: le is active-low; a write to register 0 is discarded when it is hardwired to zero.
    always_comb begin
        wr_en = ~le;
        if ((R0_ZERO != 0) && (rc == '0)) begin
            wr_en = 1'b0;
        end
    end

    // Writeback address match per read port, only for writes that will really land.
    always_comb begin
        wb_hit_a = wr_en && (ra == rc);
        wb_hit_b = wr_en && (rb == rc);
    end

    // Read muxes: reset forces zero, then register-0 rule, then same-cycle forwarding, then stored value.
    always_comb begin
        A = regs_q[ra];
        B = regs_q[rb];
        if ((BYPASS != 0) && wb_hit_a) begin
            A = C;
        end
        if ((BYPASS != 0) && wb_hit_b) begin
            B = C;
        end
        if ((R0_ZERO != 0) && (ra == '0)) begin
            A = '0;
        end
        if ((R0_ZERO != 0) && (rb == '0)) begin
            B = '0;
        end
        if (clr) begin
            A = '0;
            B = '0;
        end
    end

    // Read-after-write hazard: a busy source is fine only when its value is being forwarded this cycle.
    always_comb begin
        haz_a     = busy_q[ra] && !((BYPASS != 0) && wb_hit_a);
        haz_b     = busy_q[rb] && !((BYPASS != 0) && wb_hit_b);
        stall     = ((haz_a && use_a) || (haz_b && use_b)) && !clr;
        issue_eff = issue_v && !stall;
    end

    // Scoreboard next state: writeback clears, an accepted issue sets, and the set wins on a collision.
    always_comb begin
        busy_d = busy_q;
        if (!le) begin
            busy_d[rc] = 1'b0;
        end
        if (issue_eff) begin
            busy_d[issue_rd] = 1'b1;
        end
        if (R0_ZERO != 0) begin
            busy_d[0] = 1'b0;
        end
    end

    // Register storage: cleared asynchronously, written on the rising edge.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[rc] <= C;
        end
    end

    // Scoreboard register: reset discards every pending write.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: tb/tb_register_file_sb.sv
module tb_register_file_sb;

    logic        clk;
    logic        clr;
    logic [3:0]  ra, rb, rc, issue_rd;
    logic [31:0] C;
    logic        use_a, use_b, le, issue_v;

    logic [31:0] a0, b0, a1, b1, a2, b2;
    logic        st0, st1, st2;
    logic [15:0] busy0, busy1, busy2;

    logic [2:0]  ra3, rb3, rc3, ird3;
    logic [15:0] c3, a3, b3;
    logic        le3, st3;
    logic        iv3, ua3, ub3;
    logic [7:0]  busy3;

    int checks;
    int failures;

    register_file_sb #(.DATA_W(32), .ADDR_W(4), .BYPASS(1), .R0_ZERO(0)) u0 (
        .clk(clk), .clr(clr), .ra(ra), .rb(rb), .A(a0), .B(b0), .use_a(use_a), .use_b(use_b),
        .rc(rc), .C(C), .le(le), .issue_v(issue_v), .issue_rd(issue_rd), .stall(st0), .busy(busy0));

    register_file_sb #(.DATA_W(32), .ADDR_W(4), .BYPASS(0), .R0_ZERO(0)) u1 (
        .clk(clk), .clr(clr), .ra(ra), .rb(rb), .A(a1), .B(b1), .use_a(use_a), .use_b(use_b),
        .rc(rc), .C(C), .le(le), .issue_v(issue_v), .issue_rd(issue_rd), .stall(st1), .busy(busy1));

    register_file_sb #(.DATA_W(32), .ADDR_W(4), .BYPASS(1), .R0_ZERO(1)) u2 (
        .clk(clk), .clr(clr), .ra(ra), .rb(rb), .A(a2), .B(b2), .use_a(use_a), .use_b(use_b),
        .rc(rc), .C(C), .le(le), .issue_v(issue_v), .issue_rd(issue_rd), .stall(st2), .busy(busy2));

    register_file_sb #(.DATA_W(16), .ADDR_W(3), .BYPASS(1), .R0_ZERO(0)) u3 (
        .clk(clk), .clr(clr), .ra(ra3), .rb(rb3), .A(a3), .B(b3), .use_a(ua3), .use_b(ub3),
        .rc(rc3), .C(c3), .le(le3), .issue_v(iv3), .issue_rd(ird3), .stall(st3), .busy(busy3));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        le = 1'b1; issue_v = 1'b0; use_a = 1'b0; use_b = 1'b0;
        rc = 4'd0; C = 32'h0; issue_rd = 4'd0; ra = 4'd0; rb = 4'd0;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        idle();
        #1;
        checks++; if (a0 !== 32'h0 || b0 !== 32'h0) begin failures++; $display("FAIL reset_ab: got A=%h B=%h expected 0", a0, b0); end
        checks++; if (busy0 !== 16'h0 || st0 !== 1'b0) begin failures++; $display("FAIL reset_busy: got busy=%h stall=%b expected 0/0", busy0, st0); end
        tick();
        clr = 1'b0;
        // reg5 = DEADBEEF, and register 2 gets a pending writer
        le = 1'b0; rc = 4'd5; C = 32'hDEADBEEF; issue_v = 1'b1; issue_rd = 4'd2;
        tick();
        idle(); ra = 4'd5; rb = 4'd5;
        #1;
        checks++; if (a0 !== 32'hDEADBEEF) begin failures++; $display("FAIL write_read5: got %h expected deadbeef", a0); end
        checks++; if (busy0 !== 16'h0004) begin failures++; $display("FAIL issue_busy2: got %h expected 0004", busy0); end
        // asynchronous clear in the middle of a cycle
        clr = 1'b1;
        #1;
        checks++; if (a0 !== 32'h0 || b0 !== 32'h0) begin failures++; $display("FAIL midrun_clr_ab: got A=%h B=%h expected 0", a0, b0); end
        checks++; if (busy0 !== 16'h0) begin failures++; $display("FAIL midrun_clr_busy: got %h expected 0", busy0); end
        clr = 1'b0;
        checks++; if (a0 !== 32'h0) begin failures++; $display("FAIL clr_regs: got %h expected 0", a0); end
        le = 1'b0; rc = 4'd3; C = 32'h12345678;
        tick();
        idle(); ra = 4'd3;
        #1;
        checks++; if (a0 !== 32'h12345678) begin failures++; $display("FAIL readback3: got %h expected 12345678", a0); end
    endtask

    task automatic test_bypass();
        le = 1'b0; rc = 4'd7; C = 32'h1;
        tick();
        le = 1'b0; rc = 4'd7; C = 32'hABCD; ra = 4'd7; rb = 4'd7;
        #1;
        checks++; if (a0 !== 32'hABCD || b0 !== 32'hABCD) begin failures++; $display("FAIL bypass_on: got A=%h B=%h expected abcd", a0, b0); end
        checks++; if (a1 !== 32'h1 || b1 !== 32'h1) begin failures++; $display("FAIL bypass_off: got A=%h B=%h expected 1", a1, b1); end
        tick();
        idle(); ra = 4'd7; rb = 4'd7;
        #1;
        checks++; if (a1 !== 32'hABCD || b1 !== 32'hABCD) begin failures++; $display("FAIL bypass_off_next: got A=%h B=%h expected abcd", a1, b1); end
    endtask

    task automatic test_hazard();
        idle(); issue_v = 1'b1; issue_rd = 4'd4;
        tick();
        idle();
        #1;
        checks++; if (busy0[4] !== 1'b1 || busy1[4] !== 1'b1) begin failures++; $display("FAIL busy4_set: got %b/%b expected 1/1", busy0[4], busy1[4]); end
        ra = 4'd4; use_a = 1'b1; issue_v = 1'b1; issue_rd = 4'd8;
        #1;
        checks++; if (st0 !== 1'b1) begin failures++; $display("FAIL stall_raw: got %b expected 1", st0); end
        tick();
        checks++; if (busy0[8] !== 1'b0) begin failures++; $display("FAIL issue_during_stall: got %b expected 0", busy0[8]); end
        issue_v = 1'b0; use_a = 1'b0;
        #1;
        checks++; if (st0 !== 1'b0) begin failures++; $display("FAIL stall_unused_port: got %b expected 0", st0); end
        // same source on port B only
        rb = 4'd4; use_b = 1'b1;
        #1;
        checks++; if (st0 !== 1'b1) begin failures++; $display("FAIL stall_port_b: got %b expected 1", st0); end
        use_b = 1'b0; use_a = 1'b1; le = 1'b0; rc = 4'd4; C = 32'h44;
        #1;
        checks++; if (st0 !== 1'b0 || a0 !== 32'h44) begin failures++; $display("FAIL wb_cycle_bypass: got stall=%b A=%h expected 0/44", st0, a0); end
        checks++; if (st1 !== 1'b1) begin failures++; $display("FAIL wb_cycle_nobypass: got %b expected 1", st1); end
        tick();
        le = 1'b1;
        #1;
        checks++; if (busy0[4] !== 1'b0 || busy1[4] !== 1'b0) begin failures++; $display("FAIL busy4_clear: got %b/%b expected 0/0", busy0[4], busy1[4]); end
        checks++; if (st1 !== 1'b0 || a1 !== 32'h44) begin failures++; $display("FAIL nobypass_next: got stall=%b A=%h expected 0/44", st1, a1); end
        idle();
    endtask

    task automatic test_collision();
        issue_v = 1'b1; issue_rd = 4'd9;
        tick();
        le = 1'b0; rc = 4'd9; C = 32'h99; issue_v = 1'b1; issue_rd = 4'd9;
        tick();
        idle(); ra = 4'd9;
        #1;
        checks++; if (busy0[9] !== 1'b1) begin failures++; $display("FAIL collision_busy: got %b expected 1", busy0[9]); end
        checks++; if (a0 !== 32'h99) begin failures++; $display("FAIL collision_data: got %h expected 99", a0); end
        le = 1'b0; rc = 4'd9; C = 32'h98;
        tick();
        idle();
        checks++; if (busy0[9] !== 1'b0) begin failures++; $display("FAIL waw_clear: got %b expected 0", busy0[9]); end
        // writeback to a register nobody is waiting on
        le = 1'b0; rc = 4'd10; C = 32'h10;
        tick();
        idle(); ra = 4'd10;
        #1;
        checks++; if (a0 !== 32'h10 || busy0 !== 16'h0) begin failures++; $display("FAIL wb_not_busy: got A=%h busy=%h expected 10/0000", a0, busy0); end
    endtask

    task automatic test_r0_zero();
        le = 1'b0; rc = 4'd0; C = 32'hFFFFFFFF; issue_v = 1'b1; issue_rd = 4'd0; ra = 4'd0; rb = 4'd0; use_a = 1'b1;
        #1;
        checks++; if (a2 !== 32'h0 || b2 !== 32'h0 || st2 !== 1'b0) begin failures++; $display("FAIL r0_bypass: got A=%h B=%h stall=%b expected 0/0/0", a2, b2, st2); end
        checks++; if (a0 !== 32'hFFFFFFFF) begin failures++; $display("FAIL r0_plain_bypass: got %h expected ffffffff", a0); end
        tick();
        le = 1'b1; issue_v = 1'b0;
        #1;
        checks++; if (busy2[0] !== 1'b0 || a2 !== 32'h0 || st2 !== 1'b0) begin failures++; $display("FAIL r0_after: got busy0=%b A=%h stall=%b expected 0/0/0", busy2[0], a2, st2); end
        checks++; if (busy0[0] !== 1'b1 || st0 !== 1'b1 || a0 !== 32'hFFFFFFFF) begin failures++; $display("FAIL r0_normal: got busy0=%b stall=%b A=%h expected 1/1/ffffffff", busy0[0], st0, a0); end
        use_a = 1'b0; le = 1'b0; rc = 4'd0; C = 32'h0;
        tick();
        idle();
    endtask

    task automatic test_param();
        logic [15:0] exp_a, exp_b;
        for (int i = 0; i < 8; i++) begin
            le3 = 1'b0; rc3 = 3'(i); c3 = 16'(32'h1000 + i * 32'h0111);
            tick();
        end
        le3 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ra3 = 3'(i); rb3 = 3'(7 - i);
            exp_a = 16'(32'h1000 + i * 32'h0111);
            exp_b = 16'(32'h1000 + (7 - i) * 32'h0111);
            #1;
            checks++; if (a3 !== exp_a || b3 !== exp_b) begin failures++; $display("FAIL param_read%0d: got A=%h B=%h expected %h/%h", i, a3, b3, exp_a, exp_b); end
        end
        checks++; if (busy3 !== 8'h00 || st3 !== 1'b0) begin failures++; $display("FAIL param_busy: got busy=%h stall=%b expected 00/0", busy3, st3); end
    endtask

    initial begin
        checks = 0; failures = 0;
        ra3 = 3'd0; rb3 = 3'd0; rc3 = 3'd0; ird3 = 3'd0; c3 = 16'h0;
        le3 = 1'b1; iv3 = 1'b0; ua3 = 1'b0; ub3 = 1'b0;
        test_reset();
        test_bypass();
        test_hazard();
        test_collision();
        test_r0_zero();
        test_param();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
